// File: rtl/cramer_solver_if.sv
// ---------------------------------------------------------------------------
// cramer_solver_if
// Bundles the request and result channels of the 2x2 Cramer solver.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that edge. The request channel (a11..b2, in_valid/in_ready)
// flows master->slave. The result channel (x, y, det, singular, exact,
// out_valid/out_ready) flows slave->master.
//
// Signals (QW = 2*W+1):
//   a11,a12,a21,a22,b1,b2 [W-1:0]  signed coefficients / constants
//   in_valid, in_ready              request handshake
//   x, y, det [QW-1:0]              signed quotients Dx/D, Dy/D and D
//   singular, exact                 D==0 / both remainders zero
//   out_valid, out_ready            result handshake
// Modports: master = stimulus / consumer side, slave = solver side.
// ---------------------------------------------------------------------------
interface cramer_solver_if #(parameter int W = 12);
    localparam int QW = 2 * W + 1;

    logic signed [W-1:0]  a11, a12, a21, a22, b1, b2;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [QW-1:0] x, y, det;
    logic                 singular;
    logic                 exact;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output a11, a12, a21, a22, b1, b2, in_valid, out_ready,
        input  in_ready, x, y, det, singular, exact, out_valid
    );

    modport slave (
        input  a11, a12, a21, a22, b1, b2, in_valid, out_ready,
        output in_ready, x, y, det, singular, exact, out_valid
    );
endinterface

// File: rtl/cramer_solver.sv
// ---------------------------------------------------------------------------
// cramer_solver
// Solves a11*x + a12*y = b1, a21*x + a22*y = b2 by Cramer's rule.
// IDLE accepts a coefficient set, DET forms D, Dx, Dy at full precision,
// DIV runs two restoring dividers (one quotient bit per cycle, QW cycles),
// DONE presents the result until the consumer takes it.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      synchronous, active-high
//   bus        cramer_solver_if.slave (request in, result out)
//   dbg_state  current FSM state (0 IDLE, 1 DET, 2 DIV, 3 DONE)
// ---------------------------------------------------------------------------
module cramer_solver #(
    parameter int W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    cramer_solver_if.slave        bus,
    output logic [1:0]            dbg_state
);
    localparam int QW = 2 * W + 1;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DET = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  a11_q, a12_q, a21_q, a22_q, b1_q, b2_q;
    logic signed [W-1:0]  a11_d, a12_d, a21_d, a22_d, b1_d, b2_d;
    logic signed [QW-1:0] x_q, y_q, det_q, dval_q;
    logic signed [QW-1:0] x_d, y_d, det_d, dval_d;
    logic                 singular_q, exact_q, negx_q, negy_q;
    logic                 singular_d, exact_d, negx_d, negy_d;
    // Divider state: dvd registers start as dividend magnitudes and fill
    // with quotient bits from the LSB as the dividend shifts out the MSB.
    logic [QW-1:0]        dvs_q, dvdx_q, dvdy_q, remx_q, remy_q;
    logic [QW-1:0]        dvs_d, dvdx_d, dvdy_d, remx_d, remy_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [QW-1:0]        dvdx_n, dvdy_n, remx_n, remy_n;
    logic signed [QW-1:0] e11, e12, e21, e22, eb1, eb2;
    logic signed [QW-1:0] d_c, dx_c, dy_c;

    // Sign-extend before multiplying so every product is exact at QW bits.
    assign e11  = QW'(a11_q);
    assign e12  = QW'(a12_q);
    assign e21  = QW'(a21_q);
    assign e22  = QW'(a22_q);
    assign eb1  = QW'(b1_q);
    assign eb2  = QW'(b2_q);
    assign d_c  = e11 * e22 - e12 * e21;
    assign dx_c = eb1 * e22 - e12 * eb2;
    assign dy_c = e11 * eb2 - eb1 * e21;

    function automatic logic [QW-1:0] mag(input logic signed [QW-1:0] v);
        return v[QW-1] ? QW'(-v) : QW'(v);
    endfunction

    // One restoring step. The partial remainder is always below the divisor,
    // so after a successful subtract the low QW bits hold the exact result.
    function automatic void div_step(
        input  logic [QW-1:0] rem, dvd, dvs,
        output logic [QW-1:0] rem_n, dvd_n
    );
        logic [QW:0] trial;
        logic        qbit;
        trial = {rem, dvd[QW-1]};
        qbit  = (trial >= {1'b0, dvs});
        rem_n = qbit ? (trial[QW-1:0] - dvs) : trial[QW-1:0];
        dvd_n = {dvd[QW-2:0], qbit};
    endfunction

    always_comb begin
        state_d    = state_q;
        a11_d      = a11_q;
        a12_d      = a12_q;
        a21_d      = a21_q;
        a22_d      = a22_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        x_d        = x_q;
        y_d        = y_q;
        det_d      = det_q;
        dval_d     = dval_q;
        singular_d = singular_q;
        exact_d    = exact_q;
        negx_d     = negx_q;
        negy_d     = negy_q;
        dvs_d      = dvs_q;
        dvdx_d     = dvdx_q;
        dvdy_d     = dvdy_q;
        remx_d     = remx_q;
        remy_d     = remy_q;
        cnt_d      = cnt_q;

        div_step(remx_q, dvdx_q, dvs_q, remx_n, dvdx_n);
        div_step(remy_q, dvdy_q, dvs_q, remy_n, dvdy_n);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a11_d   = bus.a11;
                    a12_d   = bus.a12;
                    a21_d   = bus.a21;
                    a22_d   = bus.a22;
                    b1_d    = bus.b1;
                    b2_d    = bus.b2;
                    state_d = DET;
                end
            end
            DET: begin
                if (d_c == '0) begin
                    x_d        = '0;
                    y_d        = '0;
                    det_d      = '0;
                    singular_d = 1'b1;
                    exact_d    = 1'b0;
                    state_d    = DONE;
                end else begin
                    dval_d  = d_c;
                    dvs_d   = mag(d_c);
                    dvdx_d  = mag(dx_c);
                    dvdy_d  = mag(dy_c);
                    remx_d  = '0;
                    remy_d  = '0;
                    negx_d  = dx_c[QW-1] ^ d_c[QW-1];
                    negy_d  = dy_c[QW-1] ^ d_c[QW-1];
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                dvdx_d = dvdx_n;
                dvdy_d = dvdy_n;
                remx_d = remx_n;
                remy_d = remy_n;
                cnt_d  = cnt_q + CW'(1);
                // Last step: the outputs load straight from the final step.
                if (cnt_q == CW'(QW - 1)) begin
                    x_d        = negx_q ? -dvdx_n : dvdx_n;
                    y_d        = negy_q ? -dvdy_n : dvdy_n;
                    det_d      = dval_q;
                    singular_d = 1'b0;
                    exact_d    = (remx_n == '0) && (remy_n == '0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a11_q      <= '0;
            a12_q      <= '0;
            a21_q      <= '0;
            a22_q      <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            det_q      <= '0;
            dval_q     <= '0;
            singular_q <= 1'b0;
            exact_q    <= 1'b0;
            negx_q     <= 1'b0;
            negy_q     <= 1'b0;
            dvs_q      <= '0;
            dvdx_q     <= '0;
            dvdy_q     <= '0;
            remx_q     <= '0;
            remy_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a11_q      <= a11_d;
            a12_q      <= a12_d;
            a21_q      <= a21_d;
            a22_q      <= a22_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            x_q        <= x_d;
            y_q        <= y_d;
            det_q      <= det_d;
            dval_q     <= dval_d;
            singular_q <= singular_d;
            exact_q    <= exact_d;
            negx_q     <= negx_d;
            negy_q     <= negy_d;
            dvs_q      <= dvs_d;
            dvdx_q     <= dvdx_d;
            dvdy_q     <= dvdy_d;
            remx_q     <= remx_d;
            remy_q     <= remy_d;
            cnt_q      <= cnt_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.det       = det_q;
    assign bus.singular  = singular_q;
    assign bus.exact     = exact_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_cramer_solver.sv
// ---------------------------------------------------------------------------
// tb_cramer_solver
// Directed table of systems with hand-computed answers, random systems
// checked against an integer Cramer model, plus sequences for backpressure
// and reset in the middle of a division. Results go through an expected
// queue: pushed when a set is accepted, popped when out_valid rises.
// ---------------------------------------------------------------------------
module tb_cramer_solver;
    localparam int W        = 12;
    localparam int QW       = 2 * W + 1;
    localparam int EW       = 3 * QW + 2;
    localparam int LAT_DIV  = QW + 2;
    localparam int LAT_SING = 2;

    typedef struct {
        logic signed [W-1:0]  a11, a12, a21, a22, b1, b2;
        logic signed [QW-1:0] det, x, y;
        logic                 sing, ex;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    cramer_solver_if #(.W(W)) bus();

    cramer_solver #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   prev_exp;
    vec_t            tbl[6];

    function automatic logic [EW-1:0] pack(input logic signed [QW-1:0] d, xv, yv,
                                           input logic s, e);
        return {d, xv, yv, s, e};
    endfunction

    function automatic logic [EW-1:0] dut_res();
        return {bus.det, bus.x, bus.y, bus.singular, bus.exact};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a11, a12, a21, a22, b1, b2, d, xv, yv,
                                input logic s, e);
        vec_t v;
        v.a11 = W'(a11); v.a12 = W'(a12); v.a21 = W'(a21);
        v.a22 = W'(a22); v.b1 = W'(b1); v.b2 = W'(b2);
        v.det = QW'(d); v.x = QW'(xv); v.y = QW'(yv);
        v.sing = s; v.ex = e;
        return v;
    endfunction

    // Integer reference: SV '/' and '%' truncate toward zero.
    function automatic vec_t model(input vec_t v);
        longint d, dx, dy;
        vec_t   r;
        r  = v;
        d  = longint'(v.a11) * longint'(v.a22) - longint'(v.a12) * longint'(v.a21);
        dx = longint'(v.b1) * longint'(v.a22) - longint'(v.a12) * longint'(v.b2);
        dy = longint'(v.a11) * longint'(v.b2) - longint'(v.b1) * longint'(v.a21);
        if (d == 0) begin
            r.det = '0; r.x = '0; r.y = '0; r.sing = 1'b1; r.ex = 1'b0;
        end else begin
            r.det  = QW'(d);
            r.x    = QW'(dx / d);
            r.y    = QW'(dy / d);
            r.sing = 1'b0;
            r.ex   = ((dx % d) == 0) && ((dy % d) == 0);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", EW'(bus.in_ready), EW'(1));
    endtask

    task automatic drive_inputs(input vec_t v);
        bus.a11 = v.a11; bus.a12 = v.a12; bus.a21 = v.a21;
        bus.a22 = v.a22; bus.b1 = v.b1; bus.b2 = v.b2;
    endtask

    // Returns number of cycles from the accept cycle until out_valid is seen.
    task automatic accept_and_wait(input vec_t v, output int lat);
        wait_ready();
        drive_inputs(v);
        bus.in_valid = 1'b1;
        exp_q.push_back(pack(v.det, v.x, v.y, v.sing, v.ex));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        check("hold_prev_in_det", dut_res(), prev_exp);
        check("busy_flags", EW'({bus.in_ready, bus.out_valid}), EW'(2'b00));
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_compare(input string name);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=result expected=none_queued", name);
        end else begin
            e = exp_q.pop_front();
            check(name, dut_res(), e);
            prev_exp = e;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("back_to_idle", EW'({bus.in_ready, bus.out_valid}), EW'(2'b10));
    endtask

    task automatic apply(input string name, input vec_t v);
        int lat;
        accept_and_wait(v, lat);
        check({name, "_latency"}, EW'(lat), EW'(v.sing ? LAT_SING : LAT_DIV));
        pop_compare(name);
        release_result();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int   lat;
        vec_t v;
        vec_t other;

        tbl[0] = mk(2, 1, 1, -1, 5, 1, -3, 2, 1, 1'b0, 1'b1);
        tbl[1] = mk(2, 0, 0, 2, 7, -3, 4, 3, -1, 1'b0, 1'b0);
        tbl[2] = mk(1, 2, 2, 4, 3, 6, 0, 0, 0, 1'b1, 1'b0);
        tbl[3] = mk(-2048, 2047, -2048, -2048, 0, 0, 8386560, 0, 0, 1'b0, 1'b1);
        tbl[4] = mk(3, 2, 1, 4, -7, 5, 10, -3, 2, 1'b0, 1'b0);
        tbl[5] = mk(-2048, -2048, 2047, -2048, 2047, -2048, 8386560, -1, 0, 1'b0, 1'b0);

        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        drive_inputs(tbl[0]);
        prev_exp      = '0;
        repeat (3) @(negedge clk);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        // Reset won over in_valid on every edge above.
        check("reset_flags", EW'({bus.in_ready, bus.out_valid}), EW'(2'b10));
        check("reset_outputs", dut_res(), '0);
        check("reset_state", EW'(dbg_state), EW'(0));

        for (int i = 0; i < 6; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                v.a11 = W'($urandom_range(0, 4095)); v.a12 = W'($urandom_range(0, 4095));
                v.a21 = W'($urandom_range(0, 4095)); v.a22 = W'($urandom_range(0, 4095));
                v.b1  = W'($urandom_range(0, 4095)); v.b2  = W'($urandom_range(0, 4095));
            end else begin
                v.a11 = W'($urandom_range(0, 4) - 2); v.a12 = W'($urandom_range(0, 4) - 2);
                v.a21 = W'($urandom_range(0, 4) - 2); v.a22 = W'($urandom_range(0, 4) - 2);
                v.b1  = W'($urandom_range(0, 20) - 10); v.b2 = W'($urandom_range(0, 20) - 10);
            end
            apply($sformatf("rand%0d", i), model(v));
        end

        // Backpressure: result must hold, requests must be ignored.
        accept_and_wait(tbl[0], lat);
        check("bp_latency", EW'(lat), EW'(LAT_DIV));
        pop_compare("bp_result");
        other = tbl[4];
        for (int i = 0; i < 10; i++) begin
            drive_inputs(other);
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold", dut_res(), prev_exp);
            check("bp_flags", EW'({bus.in_ready, bus.out_valid}), EW'(2'b01));
        end
        bus.in_valid = 1'b0;
        release_result();
        repeat (4) begin
            @(negedge clk);
            check("bp_no_ghost", EW'({bus.in_ready, bus.out_valid}), EW'(2'b10));
        end

        // Reset during DIV cycle 10 drops the operation in flight.
        wait_ready();
        drive_inputs(tbl[1]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_div_state", EW'(dbg_state), EW'(2));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_flags", EW'({bus.in_ready, bus.out_valid}), EW'(2'b10));
        check("abort_outputs", dut_res(), '0);
        check("abort_state", EW'(dbg_state), EW'(0));
        prev_exp = '0;
        apply("after_abort", tbl[1]);

        check("queue_empty", EW'(exp_q.size()), EW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cramer_solver.md
CRAMER_SOLVER -- requirements
Module: cramer_solver

Interface
REQ-001 SHALL provide parameter W, default 12, signed coefficient/constant width in bits (W >= 4).
REQ-002 SHALL provide derived localparam QW = 2*W+1, width of determinants and quotients.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a11, a12, a21, a22  input  W each  signed coefficients of system a11*x+a12*y=b1, a21*x+a22*y=b2.
REQ-006 SHALL have ports b1, b2  input  W each  signed constants.
REQ-007 SHALL have port in_valid  input  1  coefficient set presented.
REQ-008 SHALL have port in_ready  output  1  block accepts a new set.
REQ-009 SHALL have ports x, y  output  QW each  signed quotients Dx/D, Dy/D.
REQ-010 SHALL have port det  output  QW  signed D.
REQ-011 SHALL have port singular  output  1  D == 0.
REQ-012 SHALL have port exact  output  1  both remainders zero.
REQ-013 SHALL have port out_valid  output  1  result valid; port out_ready  input  1  consumer accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, DET, DIV, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; in IDLE, in_valid=1 at a posedge SHALL register all six inputs and enter DET; inputs are ignored in all other states.
REQ-016 DET (one cycle) SHALL compute full-precision signed D=a11*a22-a12*a21, Dx=b1*a22-a12*b2, Dy=a11*b2-b1*a21 into QW-bit registers, with no truncation or wrap.
REQ-017 From DET: D==0 -> DONE with singular=1, x=y=0, exact=0, det=0; otherwise -> DIV.
REQ-018 DIV SHALL run two sequential 1-bit-per-cycle restoring dividers in parallel on magnitudes, exactly QW cycles, then enter DONE.
REQ-019 Quotients SHALL truncate toward zero; quotient sign = sign(dividend) XOR sign(D); remainder sign follows dividend; overflow cannot occur at width QW.
REQ-020 Latency: out_valid SHALL rise exactly QW+2 cycles after the accepting edge (non-singular), exactly 2 cycles after it (singular).
REQ-021 In DONE, out_valid=1 and x, y, det, singular, exact SHALL hold stable until the edge where out_ready=1; that edge returns to IDLE, so in_ready=1 in the following cycle (no same-cycle reaccept).
REQ-022 out_ready SHALL be ignored outside DONE; out_valid SHALL be 0 in IDLE, DET, DIV.
REQ-023 exact SHALL be 1 iff both Dx mod D and Dy mod D are zero and singular=0.
REQ-024 Outputs SHALL change only on entry to DONE; x, y, det, singular, exact retain last result while in IDLE/DET/DIV.

Reset
REQ-025 reset=1 at a posedge SHALL force IDLE from any state, including mid-DIV, discarding the operation in progress.
REQ-026 Reset values: in_ready=1, out_valid=0, x=0, y=0, det=0, singular=0, exact=0; divider registers cleared.
REQ-027 reset SHALL take priority over in_valid and out_ready on the same edge.

Verification (W=12)
REQ-028 2x+y=5, x-y=1, out_ready=1 -> out_valid exactly 27 cycles after accept; det=-3, x=2, y=1, exact=1, singular=0.
REQ-029 2x+0y=7, 0x+2y=-3 -> det=4, x=3, y=-1, exact=0 (truncation toward zero, negative quotient).
REQ-030 x+2y=3, 2x+4y=6 -> out_valid 2 cycles after accept; singular=1, det=0, x=y=0, exact=0.
REQ-031 a11=a22=-2048, a12=2047, a21=-2048, b1=b2=0 -> det=8386560 (no wrap), x=y=0, exact=1.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout, new in_valid ignored; then out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
REQ-033 reset=1 for one cycle at DIV cycle 10 -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; subsequent set computes correctly.
